dcache_tag_pipe: RTL and testbench
==================================

# dcache_tag_pipe

Parametrised L1 data cache tag stage that replaces the fixed-geometry tag stage in the instruction pipeline. It holds per-way tags and valid bits for NUM_WAYS × NUM_SETS lines, serves one pipeline lookup port and one L2 snoop port per cycle, and bypasses same-cycle fills. It adds two features the previous stage lacked: a registered per-way hit vector and a sequenced invalidate-all (flush) engine. It sits between operand fetch and the dcache data stage.

## Interface
- NUM_WAYS, 4, associativity (power of two, ≥1)
- NUM_SETS, 64, sets per way (power of two, ≥2)
- LINE_BYTES, 64, cache line size in bytes
- ADDR_WIDTH, 32, address width; SET_W = log2(NUM_SETS), OFS_W = log2(LINE_BYTES), TAG_W = ADDR_WIDTH − SET_W − OFS_W
- NUM_THREADS, 4, hardware threads; TID_W = log2(NUM_THREADS)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- of_instruction_valid  in  1  instruction present from operand fetch
- of_is_mem / of_is_load  in  1 / 1  memory-pipe instruction / load
- of_thread_idx  in  TID_W  issuing thread
- of_base, of_offset  in  ADDR_WIDTH each  address operands
- wb_rollback_en, wb_rollback_thread_idx  in  1, TID_W  squash
- dt_instruction_valid  out  1  registered access valid
- dt_thread_idx  out  TID_W;  dt_request_addr  out  ADDR_WIDTH
- dt_valid  out  NUM_WAYS;  dt_tag  out  NUM_WAYS×TAG_W (way w at [w*TAG_W +: TAG_W])
- dt_hit_oh  out  NUM_WAYS  valid & tag match, per way
- dt_retry  out  1  access arrived during flush; must be rolled back
- l2i_dtag_update_en_oh  in  NUM_WAYS;  l2i_dtag_update_set  in  SET_W;  l2i_dtag_update_tag  in  TAG_W;  l2i_dtag_update_valid  in  1
- l2i_snoop_en  in  1;  l2i_snoop_set  in  SET_W
- dt_snoop_valid  out  NUM_WAYS;  dt_snoop_tag  out  NUM_WAYS×TAG_W
- flush_req  in  1  start invalidate-all (pulse)
- flush_busy  out  1  sweep in progress;  flush_done  out  1  one-cycle pulse at completion

## Operation
- Address: addr = of_base + of_offset, modulo 2^ADDR_WIDTH. set = addr[OFS_W +: SET_W], tag = addr[ADDR_WIDTH−1 : OFS_W+SET_W]. IO address: addr[ADDR_WIDTH−1 : ADDR_WIDTH−16] all ones.
- access_en = of_instruction_valid & of_is_mem & !(wb_rollback_en & wb_rollback_thread_idx == of_thread_idx).
- Lookup when access_en & of_is_load & !io & state==IDLE: read all ways at set; register dt_tag, dt_valid, dt_hit_oh[w] = valid[w] & (tag[w] == request tag). Otherwise dt_tag/dt_valid/dt_hit_oh hold, except dt_hit_oh cleared to 0 when no lookup occurs.
- Bypass: if l2i_dtag_update_en_oh[w] and update set == lookup (or snoop) set in same cycle, way w returns the new tag and valid.
- Update: for each w with en_oh[w], tag[w][set] ← update_tag, valid[w][set] ← update_valid.
- Snoop: when l2i_snoop_en, register dt_snoop_tag/dt_snoop_valid for snoop set (with bypass); else hold.
- Flush FSM: IDLE --flush_req--> SWEEP (ptr=0). SWEEP: clear valid of all ways at ptr; ptr++; at ptr==NUM_SETS−1 go to DONE. DONE: flush_done=1 for one cycle, → IDLE. flush_busy=1 in SWEEP and DONE. flush_req outside IDLE ignored.
- Sweep clear beats a same-cycle update to the same set (valid ends 0; tag written). Updates to other sets apply normally.
- Accesses with access_en while flush_busy: dt_instruction_valid=1, dt_retry=1, dt_hit_oh=0, no array read.

## Timing
- Lookup and snoop latency: 1 cycle. Update visible to a lookup in the same cycle (bypass) and thereafter.
- Flush: flush_busy rises the cycle after flush_req; NUM_SETS sweep cycles, then flush_done; total NUM_SETS+1 busy cycles.
- Reset (async, any time incl. mid-sweep): all valid bits 0, FSM IDLE, ptr 0; all outputs 0 (dt_*, dt_snoop_*, flush_busy, flush_done, dt_retry). Tag storage unreset.
- dt_instruction_valid, dt_thread_idx, dt_request_addr, dt_retry update every cycle.

## Test plan
- Fill way 2 set 5 tag 0x1A3 valid; next cycle load addr with set 5/tag 0x1A3 -> dt_hit_oh=4'b0100, dt_valid[2]=1.
- Same-cycle fill and load to set 9 way 0 -> dt_valid[0]=1, dt_tag[0]=fill tag, dt_hit_oh[0]=1 (bypass).
- Rollback of thread 1 while thread 1 load arrives -> dt_instruction_valid=0; thread 2 load same cycle -> 1.
- Load to 0xFFFF0040 -> dt_instruction_valid=1, dt_hit_oh=0, dt_tag unchanged.
- Fill all sets, pulse flush_req -> flush_busy high 65 cycles (NUM_SETS=64), flush_done one pulse, every subsequent lookup misses; load during sweep -> dt_retry=1.
- Assert reset at sweep cycle 10 -> flush_busy=0 immediately, all lookups miss, new flush_req accepted.

Source files
------------

// File: rtl/dcache_tag_pipe_if.sv
// Port bundle for the dcache tag stage: operand-fetch request, rollback, L2 fill/snoop,
// flush control and the registered tag/snoop results.
interface dcache_tag_pipe_if #(
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 64,
  parameter int LINE_BYTES  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_THREADS = 4
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int OFS_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_WIDTH - SET_W - OFS_W;
  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic                      of_instruction_valid;
  logic                      of_is_mem;
  logic                      of_is_load;
  logic [TID_W-1:0]          of_thread_idx;
  logic [ADDR_WIDTH-1:0]     of_base;
  logic [ADDR_WIDTH-1:0]     of_offset;
  logic                      wb_rollback_en;
  logic [TID_W-1:0]          wb_rollback_thread_idx;

  logic                      dt_instruction_valid;
  logic [TID_W-1:0]          dt_thread_idx;
  logic [ADDR_WIDTH-1:0]     dt_request_addr;
  logic [NUM_WAYS-1:0]       dt_valid;
  logic [NUM_WAYS*TAG_W-1:0] dt_tag;
  logic [NUM_WAYS-1:0]       dt_hit_oh;
  logic                      dt_retry;

  logic [NUM_WAYS-1:0]       l2i_dtag_update_en_oh;
  logic [SET_W-1:0]          l2i_dtag_update_set;
  logic [TAG_W-1:0]          l2i_dtag_update_tag;
  logic                      l2i_dtag_update_valid;
  logic                      l2i_snoop_en;
  logic [SET_W-1:0]          l2i_snoop_set;
  logic [NUM_WAYS-1:0]       dt_snoop_valid;
  logic [NUM_WAYS*TAG_W-1:0] dt_snoop_tag;

  logic                      flush_req;
  logic                      flush_busy;
  logic                      flush_done;

  modport master (
    output of_instruction_valid, of_is_mem, of_is_load, of_thread_idx, of_base, of_offset,
    output wb_rollback_en, wb_rollback_thread_idx,
    output l2i_dtag_update_en_oh, l2i_dtag_update_set, l2i_dtag_update_tag, l2i_dtag_update_valid,
    output l2i_snoop_en, l2i_snoop_set, flush_req,
    input  dt_instruction_valid, dt_thread_idx, dt_request_addr, dt_valid, dt_tag, dt_hit_oh,
    input  dt_retry, dt_snoop_valid, dt_snoop_tag, flush_busy, flush_done
  );

  modport slave (
    input  of_instruction_valid, of_is_mem, of_is_load, of_thread_idx, of_base, of_offset,
    input  wb_rollback_en, wb_rollback_thread_idx,
    input  l2i_dtag_update_en_oh, l2i_dtag_update_set, l2i_dtag_update_tag, l2i_dtag_update_valid,
    input  l2i_snoop_en, l2i_snoop_set, flush_req,
    output dt_instruction_valid, dt_thread_idx, dt_request_addr, dt_valid, dt_tag, dt_hit_oh,
    output dt_retry, dt_snoop_valid, dt_snoop_tag, flush_busy, flush_done
  );
endinterface

// File: rtl/dcache_tag_pipe.sv
// L1 dcache tag stage: per-way tag/valid arrays, one lookup + one snoop per cycle with
// same-cycle fill bypass, registered hit vector, and a one-set-per-cycle flush sweep.
module dcache_tag_pipe #(
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 64,
  parameter int LINE_BYTES  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_THREADS = 4
) (
  input  logic             clk,
  input  logic             reset,
  dcache_tag_pipe_if.slave bus
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int OFS_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_WIDTH - SET_W - OFS_W;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SET_W-1:0]  ptr, ptr_nxt;

  logic [TAG_W-1:0]    tag_mem   [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [SET_W-1:0]      req_set;
  logic [TAG_W-1:0]      req_tag;
  logic                  is_io;
  logic                  squashed;
  logic                  access_en;
  logic                  busy;
  logic                  sweep_en;
  logic                  lookup_en;

  assign req_addr  = bus.of_base + bus.of_offset;
  assign req_set   = req_addr[OFS_W +: SET_W];
  assign req_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign is_io     = &req_addr[ADDR_WIDTH-1 -: 16];
  assign squashed  = bus.wb_rollback_en && (bus.wb_rollback_thread_idx == bus.of_thread_idx);
  assign access_en = bus.of_instruction_valid && bus.of_is_mem && !squashed;
  assign busy      = (state != IDLE);
  assign sweep_en  = (state == SWEEP);
  assign lookup_en = access_en && bus.of_is_load && !is_io && !busy;

  assign bus.flush_busy = busy;
  assign bus.flush_done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (bus.flush_req) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_SET) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [NUM_WAYS-1:0]       lk_valid;
  logic [NUM_WAYS-1:0]       lk_hit;
  logic [NUM_WAYS*TAG_W-1:0] lk_tag;
  logic [NUM_WAYS-1:0]       sn_valid;
  logic [NUM_WAYS*TAG_W-1:0] sn_tag;

  // A fill landing this cycle is forwarded so both readers see the post-write line.
  always_comb begin
    lk_valid = '0;
    lk_hit   = '0;
    lk_tag   = '0;
    sn_valid = '0;
    sn_tag   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (bus.l2i_dtag_update_en_oh[w] && (bus.l2i_dtag_update_set == req_set)) begin
        lk_tag[w*TAG_W +: TAG_W] = bus.l2i_dtag_update_tag;
        lk_valid[w]              = bus.l2i_dtag_update_valid;
      end else begin
        lk_tag[w*TAG_W +: TAG_W] = tag_mem[w][req_set];
        lk_valid[w]              = valid_mem[req_set][w];
      end
      lk_hit[w] = lk_valid[w] && (lk_tag[w*TAG_W +: TAG_W] == req_tag);

      if (bus.l2i_dtag_update_en_oh[w] && (bus.l2i_dtag_update_set == bus.l2i_snoop_set)) begin
        sn_tag[w*TAG_W +: TAG_W] = bus.l2i_dtag_update_tag;
        sn_valid[w] = bus.l2i_dtag_update_valid && !(sweep_en && (ptr == bus.l2i_snoop_set));
      end else begin
        sn_tag[w*TAG_W +: TAG_W] = tag_mem[w][bus.l2i_snoop_set];
        sn_valid[w]              = valid_mem[bus.l2i_snoop_set][w];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (bus.l2i_dtag_update_en_oh[w])
        tag_mem[w][bus.l2i_dtag_update_set] <= bus.l2i_dtag_update_tag;
    end
  end

  // The sweep clear takes priority over a fill to the set currently being swept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) valid_mem[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (sweep_en && (ptr == SET_W'(s)))
            valid_mem[s][w] <= 1'b0;
          else if (bus.l2i_dtag_update_en_oh[w] && (bus.l2i_dtag_update_set == SET_W'(s)))
            valid_mem[s][w] <= bus.l2i_dtag_update_valid;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dt_instruction_valid <= 1'b0;
      bus.dt_thread_idx        <= '0;
      bus.dt_request_addr      <= '0;
      bus.dt_retry             <= 1'b0;
      bus.dt_valid             <= '0;
      bus.dt_tag               <= '0;
      bus.dt_hit_oh            <= '0;
      bus.dt_snoop_valid       <= '0;
      bus.dt_snoop_tag         <= '0;
    end else begin
      bus.dt_instruction_valid <= access_en;
      bus.dt_thread_idx        <= bus.of_thread_idx;
      bus.dt_request_addr      <= req_addr;
      bus.dt_retry             <= access_en && busy;
      if (lookup_en) begin
        bus.dt_valid  <= lk_valid;
        bus.dt_tag    <= lk_tag;
        bus.dt_hit_oh <= lk_hit;
      end else begin
        bus.dt_hit_oh <= '0;
      end
      if (bus.l2i_snoop_en) begin
        bus.dt_snoop_valid <= sn_valid;
        bus.dt_snoop_tag   <= sn_tag;
      end
    end
  end
endmodule

// File: tb/tb_dcache_tag_pipe.sv
// Randomised and directed checks of dcache_tag_pipe against an array-level cache model.
module tb_dcache_tag_pipe;
  localparam int NW = 4;
  localparam int NS = 64;
  localparam int AW = 32;
  localparam int SET_W = 6;
  localparam int OFS_W = 6;
  localparam int TAG_W = AW - SET_W - OFS_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dcache_tag_pipe_if #(.NUM_WAYS(NW), .NUM_SETS(NS), .LINE_BYTES(64), .ADDR_WIDTH(AW),
                       .NUM_THREADS(4)) bus ();

  dcache_tag_pipe #(.NUM_WAYS(NW), .NUM_SETS(NS), .LINE_BYTES(64), .ADDR_WIDTH(AW),
                    .NUM_THREADS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Cache contents as the rules describe them: plain 2-D arrays plus a flush cycle counter.
  logic [TAG_W-1:0] m_tag   [NW][NS];
  bit               m_valid [NW][NS];
  int               fc;  // -1 idle, 0..NS-1 sweeping set fc, NS = done cycle

  logic [TAG_W-1:0] pool [4] = '{20'h00ABC, 20'h12345, 20'hFEDCB, 20'h0F0F0};

  logic              e_iv, n_iv, e_retry, n_retry, e_busy, n_busy, e_done, n_done;
  logic [1:0]        e_tid, n_tid;
  logic [AW-1:0]     e_addr, n_addr;
  logic [NW-1:0]     e_valid, n_valid, e_hit, n_hit, e_sv, n_sv;
  logic [NW*TAG_W-1:0] e_tag, n_tag, e_st, n_st;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("dt_instruction_valid", bus.dt_instruction_valid, e_iv);
      chk("dt_thread_idx", bus.dt_thread_idx, e_tid);
      chk("dt_request_addr", bus.dt_request_addr, e_addr);
      chk("dt_retry", bus.dt_retry, e_retry);
      chk("dt_valid", bus.dt_valid, e_valid);
      chk("dt_tag", bus.dt_tag, e_tag);
      chk("dt_hit_oh", bus.dt_hit_oh, e_hit);
      chk("dt_snoop_valid", bus.dt_snoop_valid, e_sv);
      chk("dt_snoop_tag", bus.dt_snoop_tag, e_st);
      chk("flush_busy", bus.flush_busy, e_busy);
      chk("flush_done", bus.flush_done, e_done);
    end
  end

  task automatic model_reset();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) m_valid[w][s] = 1'b0;
    fc = -1;
    {e_iv, e_retry, e_busy, e_done, e_tid, e_addr, e_valid, e_hit, e_sv, e_tag, e_st} = '0;
    {n_iv, n_retry, n_busy, n_done, n_tid, n_addr, n_valid, n_hit, n_sv, n_tag, n_st} = '0;
  endtask

  task automatic idle();
    bus.of_instruction_valid = 1'b0;
    bus.of_is_mem = 1'b0;
    bus.of_is_load = 1'b0;
    bus.of_thread_idx = '0;
    bus.of_base = '0;
    bus.of_offset = '0;
    bus.wb_rollback_en = 1'b0;
    bus.wb_rollback_thread_idx = '0;
    bus.l2i_dtag_update_en_oh = '0;
    bus.l2i_dtag_update_set = '0;
    bus.l2i_dtag_update_tag = '0;
    bus.l2i_dtag_update_valid = 1'b0;
    bus.l2i_snoop_en = 1'b0;
    bus.l2i_snoop_set = '0;
    bus.flush_req = 1'b0;
  endtask

  task automatic drive_access(input logic [AW-1:0] base, input logic [AW-1:0] off,
                              input logic [1:0] tid, input bit ld);
    bus.of_instruction_valid = 1'b1;
    bus.of_is_mem = 1'b1;
    bus.of_is_load = ld;
    bus.of_thread_idx = tid;
    bus.of_base = base;
    bus.of_offset = off;
  endtask

  task automatic drive_fill(input logic [NW-1:0] en, input logic [SET_W-1:0] s,
                            input logic [TAG_W-1:0] t, input bit v);
    bus.l2i_dtag_update_en_oh = en;
    bus.l2i_dtag_update_set = s;
    bus.l2i_dtag_update_tag = t;
    bus.l2i_dtag_update_valid = v;
  endtask

  // Evaluate one clock of the model from the current inputs, then advance the clock.
  task automatic step();
    logic [AW-1:0] a;
    logic [SET_W-1:0] s, us, ss;
    logic [TAG_W-1:0] t, wt;
    bit acc, io, lk, busy, wv;
    a  = bus.of_base + bus.of_offset;
    s  = a[OFS_W +: SET_W];
    t  = a[AW-1 -: TAG_W];
    io = (a[31:16] == 16'hFFFF);
    us = bus.l2i_dtag_update_set;
    ss = bus.l2i_snoop_set;
    acc = bus.of_instruction_valid && bus.of_is_mem &&
          !(bus.wb_rollback_en && bus.wb_rollback_thread_idx == bus.of_thread_idx);
    busy = (fc >= 0);
    n_iv = acc;
    n_tid = bus.of_thread_idx;
    n_addr = a;
    n_retry = acc && busy;
    lk = acc && bus.of_is_load && !io && !busy;
    n_hit = '0;
    for (int w = 0; w < NW; w++) begin
      if (lk) begin
        if (bus.l2i_dtag_update_en_oh[w] && us == s) begin
          wt = bus.l2i_dtag_update_tag; wv = bus.l2i_dtag_update_valid;
        end else begin
          wt = m_tag[w][s]; wv = m_valid[w][s];
        end
        n_tag[w*TAG_W +: TAG_W] = wt;
        n_valid[w] = wv;
        n_hit[w] = wv && (wt == t);
      end
      if (bus.l2i_snoop_en) begin
        if (bus.l2i_dtag_update_en_oh[w] && us == ss) begin
          wt = bus.l2i_dtag_update_tag;
          wv = bus.l2i_dtag_update_valid && !(fc >= 0 && fc < NS && int'(ss) == fc);
        end else begin
          wt = m_tag[w][ss]; wv = m_valid[w][ss];
        end
        n_st[w*TAG_W +: TAG_W] = wt;
        n_sv[w] = wv;
      end
    end
    for (int w = 0; w < NW; w++) begin
      if (bus.l2i_dtag_update_en_oh[w]) begin
        m_tag[w][us] = bus.l2i_dtag_update_tag;
        m_valid[w][us] = bus.l2i_dtag_update_valid;
      end
    end
    if (fc >= 0 && fc < NS)
      for (int w = 0; w < NW; w++) m_valid[w][fc] = 1'b0;
    if (fc < 0) begin
      if (bus.flush_req) fc = 0;
    end else if (fc == NS) begin
      fc = -1;
    end else begin
      fc++;
    end
    n_busy = (fc >= 0);
    n_done = (fc == NS);
    @(posedge clk);
    #1;
    {e_iv, e_tid, e_addr, e_retry, e_valid, e_tag, e_hit, e_sv, e_st, e_busy, e_done} =
      {n_iv, n_tid, n_addr, n_retry, n_valid, n_tag, n_hit, n_sv, n_st, n_busy, n_done};
  endtask

  task automatic fill_all();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        idle();
        drive_fill(NW'(1 << w), SET_W'(s), pool[(s + w) % 4], 1'b1);
        step();
      end
    idle();
  endtask

  function automatic logic [AW-1:0] mk_addr(input logic [TAG_W-1:0] t, input int s);
    return {t, SET_W'(s), 6'h00};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected end before 1000000", $time);
    $fatal(1);
  end

  initial begin
    int busy_cnt, done_cnt;
    logic [AW-1:0] a, off;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset flush_busy", bus.flush_busy, 1'b0);
    chk("reset dt_hit_oh", bus.dt_hit_oh, 4'b0000);
    chk("reset dt_instruction_valid", bus.dt_instruction_valid, 1'b0);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    fill_all();

    // Fill way 2 set 5 tag 0x1A3, look it up next cycle.
    drive_fill(4'b0100, 6'd5, 20'h1A3, 1'b1);
    step();
    idle();
    drive_access(32'h001A3000, 32'h140, 2'd0, 1'b1);
    step();
    chk("fill_then_load hit_oh", bus.dt_hit_oh, 4'b0100);
    chk("fill_then_load valid2", bus.dt_valid[2], 1'b1);

    // Same-cycle fill and load, set 9 way 0.
    idle();
    drive_fill(4'b0001, 6'd9, 20'h2B4, 1'b1);
    drive_access(32'h002B4200, 32'h40, 2'd3, 1'b1);
    step();
    chk("bypass valid0", bus.dt_valid[0], 1'b1);
    chk("bypass tag0", bus.dt_tag[TAG_W-1:0], 20'h2B4);
    chk("bypass hit0", bus.dt_hit_oh[0], 1'b1);

    // Rollback squashes only the matching thread.
    idle();
    bus.wb_rollback_en = 1'b1;
    bus.wb_rollback_thread_idx = 2'd1;
    drive_access(32'h002B4200, 32'h40, 2'd1, 1'b1);
    step();
    chk("rollback same thread iv", bus.dt_instruction_valid, 1'b0);
    drive_access(32'h002B4200, 32'h40, 2'd2, 1'b1);
    step();
    chk("rollback other thread iv", bus.dt_instruction_valid, 1'b1);

    // IO load: access valid, no lookup.
    idle();
    drive_access(32'hFFFF0000, 32'h40, 2'd0, 1'b1);
    step();
    chk("io iv", bus.dt_instruction_valid, 1'b1);
    chk("io hit_oh", bus.dt_hit_oh, 4'b0000);
    chk("io tag hold", bus.dt_tag[TAG_W-1:0], 20'h2B4);
    chk("io addr", bus.dt_request_addr, 32'hFFFF0040);

    // Flush after a full fill.
    fill_all();
    busy_cnt = 0;
    done_cnt = 0;
    bus.flush_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (i == 3) chk("sweep load retry", bus.dt_retry, 1'b1);
      if (i == 3) chk("sweep load hit_oh", bus.dt_hit_oh, 4'b0000);
      busy_cnt += int'(bus.flush_busy);
      done_cnt += int'(bus.flush_done);
      idle();
      if (i == 2) drive_access(mk_addr(pool[0], 0), 32'h0, 2'd1, 1'b1);
      if (i == 10) bus.flush_req = 1'b1;  // ignored while busy
    end
    chk("flush busy cycles", busy_cnt, 65);
    chk("flush done pulses", done_cnt, 1);
    for (int s = 0; s < 4; s++) begin
      idle();
      drive_access(mk_addr(pool[s % 4], s), 32'h0, 2'd0, 1'b1);
      step();
      chk("post flush miss", bus.dt_hit_oh, 4'b0000);
    end

    // Reset in the middle of a sweep.
    fill_all();
    bus.flush_req = 1'b1;
    step();
    idle();
    repeat (10) step();
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("mid-sweep reset busy", bus.flush_busy, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    for (int s = 30; s < 34; s++) begin
      idle();
      drive_access(mk_addr(pool[(s + 1) % 4], s), 32'h0, 2'd0, 1'b1);
      step();
      chk("post reset miss", bus.dt_hit_oh, 4'b0000);
    end
    idle();
    bus.flush_req = 1'b1;
    step();
    chk("flush after reset busy", bus.flush_busy, 1'b1);
    idle();
    repeat (70) step();

    // Randomised traffic.
    fill_all();
    for (int i = 0; i < 3000; i++) begin
      idle();
      a = {pool[$urandom_range(0, 3)], SET_W'($urandom_range(0, NS - 1)), 6'($urandom)};
      if ($urandom_range(0, 15) == 0) a[31:16] = 16'hFFFF;
      off = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      bus.of_instruction_valid = ($urandom_range(0, 3) != 0);
      bus.of_is_mem = ($urandom_range(0, 4) != 0);
      bus.of_is_load = ($urandom_range(0, 3) != 0);
      bus.of_thread_idx = 2'($urandom);
      bus.of_base = a - off;
      bus.of_offset = off;
      bus.wb_rollback_en = ($urandom_range(0, 5) == 0);
      bus.wb_rollback_thread_idx = 2'($urandom);
      if ($urandom_range(0, 2) == 0)
        drive_fill(4'($urandom),
                   ($urandom_range(0, 1) == 0) ? a[OFS_W +: SET_W] : SET_W'($urandom),
                   pool[$urandom_range(0, 3)], ($urandom_range(0, 3) != 0));
      bus.l2i_snoop_en = ($urandom_range(0, 2) == 0);
      bus.l2i_snoop_set = ($urandom_range(0, 1) == 0) ? bus.l2i_dtag_update_set
                                                      : SET_W'($urandom);
      bus.flush_req = ($urandom_range(0, 399) == 0);
      step();
    end
    idle();
    repeat (3) step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
